// File: rtl/dmem_req_unit.sv
// rtl/dmem_req_unit.sv - MEM-stage data-memory requester; optional response timeout under DMEM_TIMEOUT_EN
module dmem_req_unit #(
    parameter int width = 32
`ifdef DMEM_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEM_valid_i,
    input  logic             MEM_mem_read_i,
    input  logic             MEM_mem_write_i,
    input  logic [2:0]       MEM_funct3_i,
    input  logic [width-1:0] MEM_alu_out_i,
    input  logic [width-1:0] MEM_rs2_i,
    input  logic             dmem_resp_i,
    input  logic [width-1:0] dmem_rdata_i,
    output logic             dmem_read_o,
    output logic             dmem_write_o,
    output logic [width-1:0] dmem_address_o,
    output logic [width-1:0] dmem_wdata_o,
    output logic [3:0]       dmem_wmask_o,
    output logic             MEM_stall_o,
    output logic [width-1:0] MEM_rdata_o,
    output logic [width-1:0] MEM_addr_o,
`ifdef DMEM_TIMEOUT_EN
    output logic             dmem_timeout_o,
`endif
    output logic             MEM_misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               read_q, write_q;
    logic [width-1:0]   addr_q, wdata_q;
    logic [3:0]         wmask_q;
    logic [width-1:0]   rdata_q, maddr_q;

    logic [1:0]         off;
    logic               misalign_raw;
    logic               access;
    logic               req;
    logic               is_write;
    logic [width-1:0]   wdata_d;
    logic [3:0]         wmask_d;
    logic               resp_done;
    logic               to_hit;

    assign off      = MEM_alu_out_i[1:0];
    assign access   = MEM_valid_i & (MEM_mem_read_i | MEM_mem_write_i);
    assign is_write = MEM_mem_write_i;

    // Byte-lane replication lets the cache take data straight off the lane selected by wmask.
    always_comb begin
        misalign_raw = 1'b0;
        wdata_d      = MEM_rs2_i;
        wmask_d      = 4'b1111;
        case (MEM_funct3_i)
            3'b000, 3'b100: begin
                wdata_d = {4{MEM_rs2_i[7:0]}};
                wmask_d = 4'b0001 << off;
            end
            3'b001, 3'b101: begin
                wdata_d      = {2{MEM_rs2_i[15:0]}};
                wmask_d      = 4'b0011 << off;
                misalign_raw = off[0];
            end
            default: begin
                misalign_raw = (off != 2'b00);
            end
        endcase
    end

    assign MEM_misalign_o = access & misalign_raw;
    assign req            = access & ~misalign_raw;
    assign resp_done      = (state_q == BUSY) & dmem_resp_i;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic       timeout_q;

    // A response on the final counted cycle still completes normally.
    assign to_hit         = (state_q == BUSY) & ~dmem_resp_i & (cnt_q == TO_LAST);
    assign dmem_timeout_o = timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_hit;
            if (state_q == IDLE && req) begin
                cnt_q <= 8'd0;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (dmem_resp_i || to_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        MEM_stall_o    = 1'b0;
        dmem_read_o    = 1'b0;
        dmem_write_o   = 1'b0;
        dmem_address_o = {addr_q[width-1:2], 2'b00};
        dmem_wdata_o   = wdata_q;
        dmem_wmask_o   = wmask_q;
        MEM_rdata_o    = rdata_q;
        MEM_addr_o     = maddr_q;
        case (state_q)
            IDLE: begin
                MEM_stall_o = req;
            end
            BUSY: begin
                MEM_stall_o  = 1'b1;
                dmem_read_o  = read_q;
                dmem_write_o = write_q;
            end
            default: begin
                MEM_stall_o = 1'b0;
            end
        endcase
    end

    // Request registers load only from IDLE, so MEM inputs are ignored while BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= 4'b0000;
            rdata_q <= '0;
            maddr_q <= '0;
        end else begin
            if (state_q == IDLE && req) begin
                read_q  <= ~is_write;
                write_q <= is_write;
                addr_q  <= MEM_alu_out_i;
                wdata_q <= is_write ? wdata_d : '0;
                wmask_q <= is_write ? wmask_d : 4'b0000;
            end
            if (resp_done) begin
                maddr_q <= addr_q;
                if (read_q) begin
                    rdata_q <= dmem_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_req_unit.sv
// tb/tb_dmem_req_unit.sv - scoreboard bench for dmem_req_unit
module tb_dmem_req_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MEM_valid_i = 1'b0;
    logic        MEM_mem_read_i = 1'b0;
    logic        MEM_mem_write_i = 1'b0;
    logic [2:0]  MEM_funct3_i = 3'b000;
    logic [31:0] MEM_alu_out_i = '0;
    logic [31:0] MEM_rs2_i = '0;
    logic        dmem_resp_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        dmem_read_o, dmem_write_o, MEM_stall_o, MEM_misalign_o;
    logic [31:0] dmem_address_o, dmem_wdata_o, MEM_rdata_o, MEM_addr_o;
    logic [3:0]  dmem_wmask_o;
`ifdef DMEM_TIMEOUT_EN
    logic        dmem_timeout_o;
`endif

    int n_vec = 0;
    int n_err = 0;
    int last_timeouts = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dmem_req_unit #(
        .width(32)
`ifdef DMEM_TIMEOUT_EN
        , .TIMEOUT(4)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .MEM_valid_i(MEM_valid_i),
        .MEM_mem_read_i(MEM_mem_read_i),
        .MEM_mem_write_i(MEM_mem_write_i),
        .MEM_funct3_i(MEM_funct3_i),
        .MEM_alu_out_i(MEM_alu_out_i),
        .MEM_rs2_i(MEM_rs2_i),
        .dmem_resp_i(dmem_resp_i),
        .dmem_rdata_i(dmem_rdata_i),
        .dmem_read_o(dmem_read_o),
        .dmem_write_o(dmem_write_o),
        .dmem_address_o(dmem_address_o),
        .dmem_wdata_o(dmem_wdata_o),
        .dmem_wmask_o(dmem_wmask_o),
        .MEM_stall_o(MEM_stall_o),
        .MEM_rdata_o(MEM_rdata_o),
        .MEM_addr_o(MEM_addr_o),
`ifdef DMEM_TIMEOUT_EN
        .dmem_timeout_o(dmem_timeout_o),
`endif
        .MEM_misalign_o(MEM_misalign_o)
    );

    // Entered and left at posedge+1; drives one instruction through MEM until the stall drops.
    task automatic do_access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rs2, input int resp_after,
                             input logic [31:0] rdata, input exp_t e, input int exp_stall, input int exp_req);
        exp_t got;
        bit   seen = 0;
        bit   done = 0;
        int   stalls = 0;
        int   reqs = 0;
        got = '{rd: 1'bx, wr: 1'bx, addr: 'x, wdata: 'x, mask: 'x};
        MEM_valid_i = 1'b1;
        MEM_mem_read_i = rd;
        MEM_mem_write_i = wr;
        MEM_funct3_i = f3;
        MEM_alu_out_i = addr;
        MEM_rs2_i = rs2;
        exp_q.push_back(e);
        last_timeouts = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (dmem_read_o || dmem_write_o) begin
                reqs++;
                if (!seen) begin
                    seen = 1;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL %s scoreboard: request seen, expected none", name);
                    end else begin
                        got = exp_q.pop_front();
                    end
                end
                n_vec++;
                if (dmem_read_o !== got.rd || dmem_write_o !== got.wr || dmem_address_o !== got.addr ||
                    dmem_wdata_o !== got.wdata || dmem_wmask_o !== got.mask) begin
                    n_err++;
                    $display("FAIL %s request cyc%0d: got rd=%b wr=%b a=%h d=%h m=%b, want rd=%b wr=%b a=%h d=%h m=%b",
                             name, cyc, dmem_read_o, dmem_write_o, dmem_address_o, dmem_wdata_o, dmem_wmask_o,
                             got.rd, got.wr, got.addr, got.wdata, got.mask);
                end
            end
`ifdef DMEM_TIMEOUT_EN
            if (dmem_timeout_o) last_timeouts++;
`endif
            if (MEM_stall_o) stalls++;
            else done = 1;
            if (!done) begin
                if (reqs > 0 && reqs == resp_after) begin
                    dmem_resp_i = 1'b1;
                    dmem_rdata_i = rdata;
                end
                @(posedge clk);
                #1;
                dmem_resp_i = 1'b0;
            end
        end
        n_vec++;
        if (!done || !seen) begin
            n_err++;
            $display("FAIL %s completion: done=%0d seen=%0d, want both 1", name, done, seen);
        end
        n_vec++;
        if (stalls != exp_stall) begin
            n_err++;
            $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, exp_stall);
        end
        n_vec++;
        if (reqs != exp_req) begin
            n_err++;
            $display("FAIL %s request cycles: got %0d want %0d", name, reqs, exp_req);
        end
        MEM_valid_i = 1'b0;
        MEM_mem_read_i = 1'b0;
        MEM_mem_write_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({dmem_read_o, dmem_write_o, MEM_stall_o, MEM_misalign_o} !== 4'b0000 || dmem_address_o !== 32'h0 ||
            dmem_wdata_o !== 32'h0 || dmem_wmask_o !== 4'b0000 || MEM_rdata_o !== 32'h0 || MEM_addr_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset outputs: rd=%b wr=%b st=%b mis=%b a=%h d=%h m=%b r=%h ma=%h, want all 0",
                     dmem_read_o, dmem_write_o, MEM_stall_o, MEM_misalign_o, dmem_address_o, dmem_wdata_o,
                     dmem_wmask_o, MEM_rdata_o, MEM_addr_o);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_word();
        do_access("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 32'h0,
                  '{rd: 0, wr: 1, addr: 32'h100, wdata: 32'hDEADBEEF, mask: 4'b1111}, 4, 3);
        n_vec++;
        if (MEM_addr_o !== 32'h100) begin
            n_err++;
            $display("FAIL sw MEM_addr_o: got %h want 00000100", MEM_addr_o);
        end
    endtask

    task automatic test_store_sub();
        do_access("sb", 0, 1, 3'b000, 32'h203, 32'h000000A5, 2, 32'h0,
                  '{rd: 0, wr: 1, addr: 32'h200, wdata: 32'hA5A5A5A5, mask: 4'b1000}, 3, 2);
        do_access("sh", 0, 1, 3'b001, 32'h102, 32'h1234BEEF, 1, 32'h0,
                  '{rd: 0, wr: 1, addr: 32'h100, wdata: 32'hBEEFBEEF, mask: 4'b1100}, 2, 1);
    endtask

    task automatic test_load_word();
        do_access("lw", 1, 0, 3'b010, 32'h44, 32'hFFFFFFFF, 1, 32'h12345678,
                  '{rd: 1, wr: 0, addr: 32'h44, wdata: 32'h0, mask: 4'b0000}, 2, 1);
        n_vec++;
        if (MEM_rdata_o !== 32'h12345678 || MEM_addr_o !== 32'h44) begin
            n_err++;
            $display("FAIL lw capture: got rdata=%h addr=%h want 12345678 00000044", MEM_rdata_o, MEM_addr_o);
        end
    endtask

    task automatic test_write_priority();
        do_access("rd+wr", 1, 1, 3'b010, 32'h10, 32'h0BADF00D, 1, 32'h99999999,
                  '{rd: 0, wr: 1, addr: 32'h10, wdata: 32'h0BADF00D, mask: 4'b1111}, 2, 1);
        n_vec++;
        if (MEM_rdata_o !== 32'h12345678 || MEM_addr_o !== 32'h10) begin
            n_err++;
            $display("FAIL store keeps rdata: got rdata=%h addr=%h want 12345678 00000010", MEM_rdata_o, MEM_addr_o);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] addrs [2];
        logic [2:0]  f3s [2];
        logic        wrs [2];
        addrs = '{32'h101, 32'h102};
        f3s   = '{3'b001, 3'b010};
        wrs   = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            MEM_valid_i = 1'b1;
            MEM_mem_read_i = ~wrs[i];
            MEM_mem_write_i = wrs[i];
            MEM_funct3_i = f3s[i];
            MEM_alu_out_i = addrs[i];
            #1;
            n_vec++;
            if (MEM_misalign_o !== 1'b1 || MEM_stall_o !== 1'b0) begin
                n_err++;
                $display("FAIL misalign %0d: got mis=%b stall=%b want 1 0", i, MEM_misalign_o, MEM_stall_o);
            end
            @(posedge clk);
            #2;
            n_vec++;
            if (dmem_read_o !== 1'b0 || dmem_write_o !== 1'b0 || MEM_stall_o !== 1'b0) begin
                n_err++;
                $display("FAIL misalign %0d issue: got rd=%b wr=%b stall=%b want 0 0 0",
                         i, dmem_read_o, dmem_write_o, MEM_stall_o);
            end
            MEM_valid_i = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        do_access("lbu", 1, 0, 3'b100, 32'h7, 32'h0, 2, 32'h11223344,
                  '{rd: 1, wr: 0, addr: 32'h4, wdata: 32'h0, mask: 4'b0000}, 3, 2);
        do_access("sb2", 0, 1, 3'b000, 32'h6, 32'h0000003C, 1, 32'h0,
                  '{rd: 0, wr: 1, addr: 32'h4, wdata: 32'h3C3C3C3C, mask: 4'b0100}, 2, 1);
        n_vec++;
        if (MEM_rdata_o !== 32'h11223344 || MEM_addr_o !== 32'h6) begin
            n_err++;
            $display("FAIL b2b capture: got rdata=%h addr=%h want 11223344 00000006", MEM_rdata_o, MEM_addr_o);
        end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        do_access("timeout", 1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0,
                  '{rd: 1, wr: 0, addr: 32'h300, wdata: 32'h0, mask: 4'b0000}, 5, 4);
        n_vec++;
        if (last_timeouts != 1) begin
            n_err++;
            $display("FAIL timeout pulses: got %0d want 1", last_timeouts);
        end
        n_vec++;
        if (MEM_rdata_o !== 32'h11223344 || dmem_timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL timeout after: got rdata=%h to=%b want 11223344 0", MEM_rdata_o, dmem_timeout_o);
        end
    endtask
`endif

    task automatic test_reset_mid_busy();
        MEM_valid_i = 1'b1;
        MEM_mem_read_i = 1'b1;
        MEM_mem_write_i = 1'b0;
        MEM_funct3_i = 3'b010;
        MEM_alu_out_i = 32'h80;
        @(posedge clk);
        #2;
        n_vec++;
        if (dmem_read_o !== 1'b1 || MEM_stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre-reset busy: got rd=%b stall=%b want 1 1", dmem_read_o, MEM_stall_o);
        end
        rst = 1'b0;
        MEM_valid_i = 1'b0;
        MEM_mem_read_i = 1'b0;
        #1;
        n_vec++;
        if (dmem_read_o !== 1'b0 || MEM_stall_o !== 1'b0 || dmem_address_o !== 32'h0 ||
            MEM_rdata_o !== 32'h0 || MEM_addr_o !== 32'h0) begin
            n_err++;
            $display("FAIL async reset: got rd=%b stall=%b a=%h r=%h ma=%h want all 0",
                     dmem_read_o, MEM_stall_o, dmem_address_o, MEM_rdata_o, MEM_addr_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        dmem_resp_i = 1'b1;
        dmem_rdata_i = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        dmem_resp_i = 1'b0;
        #1;
        n_vec++;
        if (MEM_rdata_o !== 32'h0 || MEM_addr_o !== 32'h0 || dmem_read_o !== 1'b0 || MEM_stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL late resp: got r=%h ma=%h rd=%b stall=%b want 0 0 0 0",
                     MEM_rdata_o, MEM_addr_o, dmem_read_o, MEM_stall_o);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_sub();
        test_load_word();
        test_write_priority();
        test_misalign();
        test_back_to_back();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_busy();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_req_unit.md
Name: dmem_req_unit

Overview:
- MEM-stage data-memory requester; the write/issue end of the load-store path whose read end is WB load extension.
- Takes the MEM instruction's control, address and store data, then issues one request per instruction to the data cache.
- For stores: builds byte-lane-replicated wdata and a 4-bit wmask. For loads: captures the raw rdata word plus byte address for WB.
- Holds a pipeline stall until the cache responds.

Parameters:
width, 32, data/address width (only 32 supported)
TIMEOUT, 255, max cycles waiting for dmem_resp_i (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low (0 = reset)
MEM_valid_i  in  1  MEM stage holds a real (non-bubble) instruction
MEM_mem_read_i  in  1  instruction is a load
MEM_mem_write_i  in  1  instruction is a store
MEM_funct3_i  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
MEM_alu_out_i  in  width  effective byte address
MEM_rs2_i  in  width  store source data
dmem_resp_i  in  1  cache response, 1-cycle pulse
dmem_rdata_i  in  width  cache read data, valid with dmem_resp_i
dmem_read_o  out  1  read request, held until response
dmem_write_o  out  1  write request, held until response
dmem_address_o  out  width  word-aligned address {addr[31:2],2'b00}
dmem_wdata_o  out  width  aligned store data
dmem_wmask_o  out  4  byte enables (0000 for reads)
MEM_stall_o  out  1  freeze IF..MEM pipeline registers
MEM_rdata_o  out  width  captured raw load word, held until next load completes
MEM_addr_o  out  width  full byte address of the last completed access
MEM_misalign_o  out  1  current MEM access is misaligned; no request issued

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs and internal registers 0. A dmem_resp_i arriving after reset release while in IDLE is ignored.
- Request present = MEM_valid_i & (read | write) & ~misalign. If read and write are both 1, treat as a write.
- Misaligned accesses:
  - h/hu with addr[0]=1.
  - w with addr[1:0]!=0.
  - MEM_misalign_o is combinational; no request is issued and the instruction passes without a stall.
- Store alignment, off = addr[1:0]:
  - sb: wdata={4{rs2[7:0]}}, wmask=4'b0001<<off.
  - sh: wdata={2{rs2[15:0]}}, wmask=4'b0011<<off.
  - sw: wdata=rs2, wmask=1111.
- FSM states:
  - IDLE: MEM_stall_o = request present (combinational). On a request, register address/wdata/wmask/read/write and go to BUSY.
  - BUSY: dmem_read_o/dmem_write_o/address/wdata/wmask driven from registers, stable; MEM_stall_o=1. On dmem_resp_i, drop the request the same edge. For loads, capture dmem_rdata_i into MEM_rdata_o. Register MEM_addr_o. Go to DONE.
  - DONE: requests 0, MEM_stall_o=0 so the pipeline advances this cycle. Next state IDLE unconditionally, so the same instruction is never reissued.
- Latency: request out 1 cycle after the instruction enters MEM. Minimum stall is 2 cycles (IDLE request cycle + BUSY with resp on its first cycle).
- Request signals never toggle while in BUSY; MEM inputs changing during BUSY are ignored.
- MEM_rdata_o / MEM_addr_o update only on completion; stores update MEM_addr_o only.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entering BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without a response: drop the request, go to DONE, leave MEM_rdata_o unchanged, pulse extra output dmem_timeout_o for 1 cycle.
  - A response arriving on the same cycle the counter hits TIMEOUT wins (normal completion, no timeout).
- Undefined: no counter and no dmem_timeout_o port; BUSY waits indefinitely.

Test Plan:
- Case 1: sw addr 0x100, rs2 0xDEADBEEF, resp after 3 BUSY cycles -> dmem_write_o=1 for exactly 3 cycles, address 0x100, wmask 1111, wdata 0xDEADBEEF; stall 4 cycles, then 0 in DONE.
- Case 2: sb addr 0x203, rs2 0x000000A5 -> address 0x200, wmask 1000, wdata 0xA5A5A5A5.
- Case 3: lw addr 0x44, resp same cycle as first BUSY with rdata 0x12345678 -> MEM_rdata_o=0x12345678, MEM_addr_o=0x44; exactly one dmem_read_o cycle; stall 2 cycles.
- Case 4: sh addr 0x101 -> MEM_misalign_o=1, no dmem_read_o/dmem_write_o, MEM_stall_o=0. Also lw addr 0x102 -> same result.
- Case 5: rst driven 0 mid-BUSY, then a resp pulse after release -> outputs 0 immediately (async), state IDLE, the late resp ignored, MEM_rdata_o stays 0.
- Case 6 (DMEM_TIMEOUT_EN, TIMEOUT=4): lw with no resp -> dmem_read_o high 4 cycles, dmem_timeout_o pulses once, stall drops in DONE, MEM_rdata_o unchanged.
